bsort_ctrl: RTL and testbench

Sequencing controller for the 8-entry bubble-sort datapath: the dual-read/dual-write register file and its compare-swap step. It multiplexes external loading of the array with the sort schedule. It runs the outer pass loop and the inner compare loop, and issues the paired write-back on each swap. It terminates early on a pass with no swaps and reports busy/done to the host.

---
 rtl/bsort_ctrl.sv | 177 +++++++++++++++++
 tb/tb_bsort_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsort_ctrl.sv
// bsort_ctrl -- sequencing controller for an N-entry bubble-sort datapath.
//
// The block drives a dual-read / dual-write register file. In IDLE it passes
// host writes straight through to write port 0. In SORT it runs one
// compare-swap per cycle over the outer pass loop (i) and the inner compare
// loop (j). It stops early after any pass that made no swaps.
//
// Ports:
//   clk_i            single clock, rising edge
//   reset_i          synchronous, active-high
//   start_i          begin a sort (sampled in IDLE only)
//   load_i           host write strobe (honoured in IDLE only, wins over start)
//   addr_i, din_i    host write address / data
//   ra0_o, ra1_o     register-file read addresses
//   rd0_i, rd1_i     register-file read data (combinational, same cycle)
//   we0_o/wa0_o/wd0_o  write port 0
//   we1_o/wa1_o/wd1_o  write port 1
//   busy_o           high while sorting
//   done_o           sticky completion flag
//   pass_o           current outer-pass index i
module bsort_ctrl #(
  parameter int N       = 8,
  parameter int DW      = 8,
  parameter int AW      = 3,
  parameter bit DESCEND = 1'b0
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          load_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] din_i,
  output logic [AW-1:0] ra0_o,
  output logic [AW-1:0] ra1_o,
  input  logic [DW-1:0] rd0_i,
  input  logic [DW-1:0] rd1_i,
  output logic          we0_o,
  output logic [AW-1:0] wa0_o,
  output logic [DW-1:0] wd0_o,
  output logic          we1_o,
  output logic [AW-1:0] wa1_o,
  output logic [DW-1:0] wd1_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] pass_o
);

  typedef enum logic {IDLE, SORT} state_e;

  // Index of the last outer pass. It is also the final j of pass 0.
  localparam logic [AW-1:0] LastIdx = AW'(N - 2);

  state_e        state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] j_q, j_d;
  logic          swapped_q, swapped_d;
  logic          done_q, done_d;

  logic          swapNow;
  logic          endOfPass;
  logic          lastPass;

  // Compare of the current neighbour pair. Equal values never swap, so the
  // sort stays stable. The sort direction is fixed at elaboration time.
  always_comb begin
    swapNow = 1'b0;
    if (state_q == SORT) begin
      swapNow = DESCEND ? (rd0_i < rd1_i) : (rd0_i > rd1_i);
    end
  end

  // Pass i compares j = 0 .. N-2-i; the last pass has a single compare.
  assign endOfPass = (j_q == (LastIdx - i_q));
  assign lastPass  = (i_q == LastIdx);

  // State register. Reset is synchronous and returns to an idle, cleared
  // controller. The array itself is owned by the register file.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      swapped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      swapped_q <= swapped_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic. In IDLE a load beats a start.
  // In SORT, the swap made this cycle also counts toward the decision to
  // run another pass, because swapped_q has not yet captured it.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    swapped_d = swapped_q;
    done_d    = done_q;
    unique case (state_q)
      IDLE: begin
        if (load_i) begin
          done_d = 1'b0;
        end else if (start_i) begin
          state_d   = SORT;
          i_d       = '0;
          j_d       = '0;
          swapped_d = 1'b0;
          done_d    = 1'b0;
        end
      end
      SORT: begin
        if (endOfPass) begin
          if (lastPass || !(swapped_q || swapNow)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            i_d       = i_q + AW'(1);
            j_d       = '0;
            swapped_d = 1'b0;
          end
        end else begin
          j_d       = j_q + AW'(1);
          swapped_d = swapped_q | swapNow;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The register file reads combinationally, so the
  // compare-swap write-back lands on the same edge. The next compare then
  // sees the moved value at j+1. Reset masks every write enable so that a
  // reset in mid-sort leaves a consistent permutation in the array.
  always_comb begin
    ra0_o = '0;
    ra1_o = AW'(1);
    we0_o = 1'b0;
    wa0_o = '0;
    wd0_o = '0;
    we1_o = 1'b0;
    wa1_o = '0;
    wd1_o = '0;
    unique case (state_q)
      IDLE: begin
        if (load_i) begin
          we0_o = 1'b1;
          wa0_o = addr_i;
          wd0_o = din_i;
        end
      end
      SORT: begin
        ra0_o = j_q;
        ra1_o = j_q + AW'(1);
        if (swapNow) begin
          we0_o = 1'b1;
          wa0_o = j_q;
          wd0_o = rd1_i;
          we1_o = 1'b1;
          wa1_o = j_q + AW'(1);
          wd1_o = rd0_i;
        end
      end
      default: ;
    endcase
    we0_o = we0_o & ~reset_i;
    we1_o = we1_o & ~reset_i;
  end

  assign busy_o = (state_q == SORT);
  assign done_o = done_q;
  assign pass_o = i_q;

endmodule

// File: tb/tb_bsort_ctrl.sv
// tb_bsort_ctrl -- directed self-checking bench for bsort_ctrl.
// Instance A sorts in ascending order and instance B in descending order.
// Each instance drives its own 8-entry register-file model.
module tb_bsort_ctrl;

  logic       clk;
  logic       reset;
  logic       startA, startB;
  logic       loadA, loadB;
  logic [2:0] addr;
  logic [7:0] din;

  logic [2:0] raA0, raA1, waA0, waA1, passA;
  logic [7:0] rdA0, rdA1, wdA0, wdA1;
  logic       weA0, weA1, busyA, doneA;

  logic [2:0] raB0, raB1, waB0, waB1, passB;
  logic [7:0] rdB0, rdB1, wdB0, wdB1;
  logic       weB0, weB1, busyB, doneB;

  logic [7:0] memA [8];
  logic [7:0] memB [8];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bsort_ctrl #(.N(8), .DW(8), .AW(3), .DESCEND(1'b0)) dutA (
    .clk_i(clk), .reset_i(reset), .start_i(startA), .load_i(loadA),
    .addr_i(addr), .din_i(din), .ra0_o(raA0), .ra1_o(raA1),
    .rd0_i(rdA0), .rd1_i(rdA1), .we0_o(weA0), .wa0_o(waA0), .wd0_o(wdA0),
    .we1_o(weA1), .wa1_o(waA1), .wd1_o(wdA1), .busy_o(busyA),
    .done_o(doneA), .pass_o(passA)
  );

  bsort_ctrl #(.N(8), .DW(8), .AW(3), .DESCEND(1'b1)) dutB (
    .clk_i(clk), .reset_i(reset), .start_i(startB), .load_i(loadB),
    .addr_i(addr), .din_i(din), .ra0_o(raB0), .ra1_o(raB1),
    .rd0_i(rdB0), .rd1_i(rdB1), .we0_o(weB0), .wa0_o(waB0), .wd0_o(wdB0),
    .we1_o(weB1), .wa1_o(waB1), .wd1_o(wdB1), .busy_o(busyB),
    .done_o(doneB), .pass_o(passB)
  );

  // Register-file models: combinational read, write on the rising edge.
  assign rdA0 = memA[raA0];
  assign rdA1 = memA[raA1];
  assign rdB0 = memB[raB0];
  assign rdB1 = memB[raB1];

  always @(posedge clk) begin
    if (weA0) memA[waA0] <= wdA0;
    if (weA1) memA[waA1] <= wdA1;
    if (weB0) memB[waB0] <= wdB0;
    if (weB1) memB[waB1] <= wdB1;
  end

  // One comparison. A failure is counted and reported.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Load eight bytes (vals[63:56] goes to address 0) through the host port.
  task automatic applyStimulus(input logic [63:0] vals, input bit useB);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      loadA = !useB;
      loadB = useB;
      addr  = 3'(k);
      din   = vals[63 - 8*k -: 8];
    end
    @(posedge clk); #1;
    loadA = 1'b0;
    loadB = 1'b0;
  endtask

  // Pulse start, then watch the sort until busy drops. This task counts busy
  // cycles, write pairs, any writes, writes of equal neighbours, and the
  // highest pass index. Inject 1 drives load+start mid-sort; inject 2
  // asserts reset in the 10th sort cycle.
  task automatic runSort(input bit useB, input int inject,
                         output int cycles, output int pairs,
                         output int writes, output int eqW,
                         output int maxPass, output bit timedOut);
    logic b, w0, w1;
    logic [7:0] r0, r1;
    logic [2:0] p;
    cycles = 0; pairs = 0; writes = 0; eqW = 0; maxPass = 0; timedOut = 1'b1;
    @(posedge clk); #1;
    if (useB) startB = 1'b1; else startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0;
    startB = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      b = useB ? busyB : busyA;
      if (!b) begin
        timedOut = 1'b0;
        break;
      end
      cycles++;
      if (inject == 2 && cycles == 10) begin
        reset = 1'b1;
        #1;
        checkOutput("reset mid-sort we0", 32'(weA0), 32'd0);
        checkOutput("reset mid-sort we1", 32'(weA1), 32'd0);
      end
      w0 = useB ? weB0 : weA0;
      w1 = useB ? weB1 : weA1;
      r0 = useB ? rdB0 : rdA0;
      r1 = useB ? rdB1 : rdA1;
      p  = useB ? passB : passA;
      if (w0 && w1) pairs++;
      if (w0 || w1) writes++;
      if (w1 && r0 == r1) eqW++;
      if (int'(p) > maxPass) maxPass = int'(p);
      if (inject == 1 && cycles == 3) begin
        loadA = 1'b1; startA = 1'b1; addr = 3'd2; din = 8'h55;
      end
      if (inject == 1 && cycles == 6) begin
        loadA = 1'b0; startA = 1'b0;
      end
    end
    if (timedOut) checkOutput("sort timeout", 32'd1, 32'd0);
  endtask

  int cyc, prs, wrs, eqw, mp;
  bit to;
  logic [8:0] mask;

  initial begin
    reset = 1'b1; startA = 1'b1; loadA = 1'b1; startB = 1'b0; loadB = 1'b0;
    addr = 3'd5; din = 8'hEE;

    // Reset held together with start and load.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", 32'(busyA), 32'd0);
    checkOutput("reset done", 32'(doneA), 32'd0);
    checkOutput("reset we0", 32'(weA0), 32'd0);
    checkOutput("reset we1", 32'(weA1), 32'd0);
    checkOutput("reset pass", 32'(passA), 32'd0);
    @(negedge clk);
    checkOutput("reset hold busy", 32'(busyA), 32'd0);
    reset = 1'b0; startA = 1'b0; loadA = 1'b0;
    @(negedge clk);
    checkOutput("idle ra0", 32'(raA0), 32'd0);
    checkOutput("idle ra1", 32'(raA1), 32'd1);
    checkOutput("idle we0", 32'(weA0), 32'd0);

    // Reverse order gives the worst case.
    applyStimulus(64'h0807060504030201, 1'b0);
    runSort(1'b0, 0, cyc, prs, wrs, eqw, mp, to);
    checkOutput("rev busy cycles", 32'(cyc), 32'd28);
    checkOutput("rev write pairs", 32'(prs), 32'd28);
    checkOutput("rev max pass", 32'(mp), 32'd6);
    checkOutput("rev done", 32'(doneA), 32'd1);
    for (int k = 0; k < 8; k++) checkOutput("rev result", 32'(memA[k]), 32'(k + 1));

    // Load and start together in IDLE: only the write happens.
    @(posedge clk); #1;
    loadA = 1'b1; startA = 1'b1; addr = 3'd0; din = 8'hAA;
    @(negedge clk);
    checkOutput("ld+st we0", 32'(weA0), 32'd1);
    checkOutput("ld+st wa0", 32'(waA0), 32'd0);
    checkOutput("ld+st wd0", 32'(wdA0), 32'hAA);
    checkOutput("ld+st we1", 32'(weA1), 32'd0);
    @(posedge clk); #1;
    loadA = 1'b0; startA = 1'b0;
    @(negedge clk);
    checkOutput("ld+st busy", 32'(busyA), 32'd0);
    checkOutput("ld clears done", 32'(doneA), 32'd0);
    checkOutput("ld+st mem0", 32'(memA[0]), 32'hAA);

    // Already-sorted input: one pass, no writes.
    applyStimulus(64'h0102030405060708, 1'b0);
    runSort(1'b0, 0, cyc, prs, wrs, eqw, mp, to);
    checkOutput("sorted cycles", 32'(cyc), 32'd7);
    checkOutput("sorted writes", 32'(wrs), 32'd0);
    checkOutput("sorted max pass", 32'(mp), 32'd0);
    checkOutput("sorted done", 32'(doneA), 32'd1);

    // Duplicates, with an early exit after pass 5.
    applyStimulus(64'h0301030202000707, 1'b0);
    runSort(1'b0, 0, cyc, prs, wrs, eqw, mp, to);
    checkOutput("dup cycles", 32'(cyc), 32'd27);
    checkOutput("dup write pairs", 32'(prs), 32'd10);
    checkOutput("dup equal writes", 32'(eqw), 32'd0);
    checkOutput("dup max pass", 32'(mp), 32'd5);
    checkOutput("dup result 0", 32'(memA[0]), 32'd0);
    checkOutput("dup result 1", 32'(memA[1]), 32'd1);
    checkOutput("dup result 2", 32'(memA[2]), 32'd2);
    checkOutput("dup result 3", 32'(memA[3]), 32'd2);
    checkOutput("dup result 4", 32'(memA[4]), 32'd3);
    checkOutput("dup result 5", 32'(memA[5]), 32'd3);
    checkOutput("dup result 6", 32'(memA[6]), 32'd7);
    checkOutput("dup result 7", 32'(memA[7]), 32'd7);

    // Load and start during SORT are ignored.
    applyStimulus(64'h0807060504030201, 1'b0);
    runSort(1'b0, 1, cyc, prs, wrs, eqw, mp, to);
    checkOutput("sort-ignore cycles", 32'(cyc), 32'd28);
    checkOutput("sort-ignore pairs", 32'(prs), 32'd28);
    for (int k = 0; k < 8; k++) checkOutput("sort-ignore result", 32'(memA[k]), 32'(k + 1));
    @(negedge clk);
    checkOutput("sort-ignore no restart", 32'(busyA), 32'd0);

    // Reset in the 10th cycle of a reverse-order sort.
    applyStimulus(64'h0807060504030201, 1'b0);
    runSort(1'b0, 2, cyc, prs, wrs, eqw, mp, to);
    checkOutput("reset-mid busy", 32'(busyA), 32'd0);
    checkOutput("reset-mid done", 32'(doneA), 32'd0);
    checkOutput("reset-mid cycles", 32'(cyc), 32'd10);
    reset = 1'b0;
    mask = '0;
    for (int k = 0; k < 8; k++) if (memA[k] <= 8'd8) mask[memA[k]] = 1'b1;
    checkOutput("reset-mid permutation", 32'(mask), 32'h1FE);

    // Descending instance with input 1..8.
    applyStimulus(64'h0102030405060708, 1'b1);
    runSort(1'b1, 0, cyc, prs, wrs, eqw, mp, to);
    checkOutput("desc cycles", 32'(cyc), 32'd28);
    checkOutput("desc done", 32'(doneB), 32'd1);
    for (int k = 0; k < 8; k++) checkOutput("desc result", 32'(memB[k]), 32'(8 - k));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
